icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
- Fetch-side controller in front of the direct-mapped instruction cache.
- Takes fetch requests from the IF stage and looks each one up in the cache.
- On a miss, it reads the 32-bit instruction from the byte-wide RAM port as four pipelined byte reads, assembles the word little-endian, writes it into the cache and returns it to IF.
- It is the cache's only writer and sits between the IF stage, the cache and the memory arbiter.

Parameters:
- ADDR_W, 32, width of the fetch address and RAM address.
- INST_W, 32, instruction width; fixed at 4 bytes.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; low freezes issue and all state transitions.
- if_req  in  1  fetch request, level; sampled only in IDLE.
- if_pc  in  ADDR_W  fetch address, word-aligned.
- flush  in  1  branch redirect; aborts the current fetch.
- inst_valid  out  1  one-cycle pulse: inst_o and inst_pc are valid.
- inst_o  out  INST_W  fetched instruction.
- inst_pc  out  ADDR_W  address of inst_o.
- cache_addr  out  ADDR_W  lookup/write address to the cache (if_pc in IDLE, latched pc otherwise).
- cache_data_i  in  INST_W  cache read data (combinational).
- cache_hit  in  1  cache hit (combinational).
- cache_work  out  1  cache write enable, one cycle.
- cache_wdata  out  INST_W  assembled word to write.
- mem_req  out  1  request for the RAM port to the arbiter.
- mem_gnt  in  1  arbiter grant this cycle; the data port has priority.
- mem_a  out  ADDR_W  RAM byte address.
- mem_wr  out  1  RAM write strobe; constantly 0.
- mem_din  in  8  RAM read byte, valid the cycle after its address.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; issue_cnt=0, recv_cnt=0, pend=0.
  - inst_valid=0, inst_o=0, inst_pc=0; cache_work=0, cache_wdata=0.
  - mem_req=0, mem_a=0, mem_wr=0.
- States:
  - IDLE: cache_addr=if_pc. On if_req & rdy & !flush:
    - hit -> HIT; latch inst_o=cache_data_i, inst_pc=if_pc.
    - miss -> FETCH; latch pc, clear counters.
  - HIT: inst_valid=1 for this cycle -> IDLE. Hit latency is one cycle after the request is sampled.
  - FETCH:
    - mem_req=1 while issue_cnt<4.
    - On rdy & mem_gnt & issue_cnt<4: mem_a=pc+issue_cnt, issue_cnt++, pend<=1; otherwise mem_a=0 and pend<=0.
    - If pend was set the previous cycle: byte[recv_cnt]<=mem_din, recv_cnt++. The receive path is not gated by rdy or mem_gnt, so an in-flight byte is never lost.
    - When recv_cnt reaches 4 -> RESP.
  - RESP (only when rdy):
    - cache_work=1, cache_wdata={b3,b2,b1,b0}, cache_addr=pc.
    - inst_valid=1, inst_o=assembled word, inst_pc=pc.
    - -> IDLE.
- Miss latency with continuous grant: request sampled at cycle 0; addresses issued cycles 1-4; bytes captured on the edges ending cycles 2-5; inst_valid in cycle 6.
- Grant gaps: each cycle without mem_gnt delays only the next issue; bytes are never reordered.
- flush:
  - In IDLE, flush beats if_req; the request is dropped.
  - In HIT, inst_valid is suppressed.
  - In FETCH, go to IDLE next cycle with no cache write and no inst_valid; any in-flight byte is discarded and pend is cleared.
  - In RESP, the cache write still happens (the word is correct) but inst_valid is suppressed.
- rdy low: no issue; state, counters and outputs hold, except capture of a pending byte. inst_valid and cache_work are forced to 0 while rdy is low.
- Reset mid-refill: immediate return to IDLE; a partially assembled word is never written to the cache.
- Width rule: pc+issue_cnt wraps modulo 2^ADDR_W.

Decomposition:
- Shared constants go in config.v:
  - InstAddrBus, InstBus, ByteBus.
  - State encodings IDLE/HIT/FETCH/RESP.
  - BytesPerInst=4.
- One sub-module is natural: refill_byte_assembler. It holds the 4x8 byte registers and recv_cnt, with a clear input and a done flag.

Test Plan:
- Cold miss, if_pc=0x1000, gnt=1, RAM bytes 0x13,0x05,0x10,0x00 -> mem_a 0x1000..0x1003 in cycles 1-4; cycle 6 has cache_work=1, inst_valid=1, inst_o=0x00100513, inst_pc=0x1000.
- Re-fetch 0x1000 after that fill -> cache_hit, inst_valid in cycle 1, no mem_req.
- Miss with mem_gnt low in cycles 2-3 -> addresses 0x1000, then 0x1001..0x1003 in cycles 4-6; correct word in cycle 8.
- flush asserted in the cycle after the second issue of a miss -> IDLE next cycle; no cache_work or inst_valid; a following hit request is served normally.
- rdy low for 3 cycles mid-refill -> byte pending at the drop is captured, issue resumes at the correct address, word is correct; rst pulse mid-refill -> all outputs 0, no cache write.

Source files
------------

// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and constants for the instruction-cache refill controller.
package icache_refill_ctrl_pkg;

    localparam int InstAddrBus  = 32;
    localparam int InstBus      = 32;
    localparam int ByteBus      = 8;
    localparam int BytesPerInst = 4;
    localparam int CntW         = $clog2(BytesPerInst + 1);
    localparam int IdxW         = $clog2(BytesPerInst);

    typedef logic [ByteBus-1:0] byte_t;
    typedef logic [CntW-1:0]    cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIT   = 2'd1,
        FETCH = 2'd2,
        RESP  = 2'd3
    } state_e;

    function automatic cnt_t byte_count(input int n);
        return cnt_t'(n);
    endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// IF-stage, cache and RAM-arbiter signals seen by the refill controller.
interface icache_refill_ctrl_if
    import icache_refill_ctrl_pkg::*;
#(
    parameter int ADDR_W = InstAddrBus,
    parameter int INST_W = InstBus
) ();

    logic              rdy;
    logic              if_req;
    logic [ADDR_W-1:0] if_pc;
    logic              flush;
    logic              inst_valid;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_pc;
    logic [ADDR_W-1:0] cache_addr;
    logic [INST_W-1:0] cache_data_i;
    logic              cache_hit;
    logic              cache_work;
    logic [INST_W-1:0] cache_wdata;
    logic              mem_req;
    logic              mem_gnt;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    byte_t             mem_din;

    modport master (
        input  rdy, if_req, if_pc, flush,
        input  cache_data_i, cache_hit,
        input  mem_gnt, mem_din,
        output inst_valid, inst_o, inst_pc,
        output cache_addr, cache_work, cache_wdata,
        output mem_req, mem_a, mem_wr
    );

    modport slave (
        output rdy, if_req, if_pc, flush,
        output cache_data_i, cache_hit,
        output mem_gnt, mem_din,
        input  inst_valid, inst_o, inst_pc,
        input  cache_addr, cache_work, cache_wdata,
        input  mem_req, mem_a, mem_wr
    );

endinterface

// File: rtl/icache_refill_ctrl_refill_byte_assembler.sv
// Collects the refill bytes in arrival order into a little-endian word.
module refill_byte_assembler
    import icache_refill_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               capture,
    input  byte_t              din,
    output logic [InstBus-1:0] word,
    output cnt_t               cnt,
    output logic               done
);

    logic [BytesPerInst-1:0][ByteBus-1:0] bytes_q, bytes_d;
    cnt_t                                 cnt_q, cnt_d;

    assign done = (cnt_q == byte_count(BytesPerInst));
    assign cnt  = cnt_q;
    assign word = bytes_q;

    always_comb begin
        bytes_d = bytes_q;
        cnt_d   = cnt_q;
        if (clear) begin
            bytes_d = '0;
            cnt_d   = '0;
        end else if (capture && !done) begin
            bytes_d[cnt_q[IdxW-1:0]] = din;
            cnt_d                    = cnt_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bytes_q <= '0;
            cnt_q   <= '0;
        end else begin
            bytes_q <= bytes_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Fetch-side controller: cache lookup, byte-wise RAM refill on miss,
// cache write-back and instruction return to the IF stage.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int ADDR_W = InstAddrBus,
    parameter int INST_W = InstBus
) (
    input  logic                 clk,
    input  logic                 rst,
    icache_refill_ctrl_if.master bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    cnt_t              issue_cnt_q, issue_cnt_d;
    logic              pend_q, pend_d;
    logic [INST_W-1:0] inst_o_q, inst_o_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;

    logic               go;
    logic               issue;
    logic               more;
    logic               last_byte;
    logic               fill_done;
    logic               fetch_flush;
    logic               asm_clear;
    logic [InstBus-1:0] asm_word;
    cnt_t               recv_cnt;
    logic               asm_done;

    assign go          = bus.if_req & bus.rdy & ~bus.flush;
    assign more        = issue_cnt_q < byte_count(BytesPerInst);
    assign issue       = (state_q == FETCH) & bus.rdy & bus.mem_gnt
                       & ~bus.flush & more;
    assign fetch_flush = (state_q == FETCH) & bus.rdy & bus.flush;

    // The final byte lands on the same edge that leaves FETCH.
    assign last_byte = pend_q
                     & (recv_cnt == byte_count(BytesPerInst - 1));
    assign fill_done = asm_done | last_byte;
    assign asm_clear = ((state_q == IDLE) & go & ~bus.cache_hit)
                     | fetch_flush;

    refill_byte_assembler u_asm (
        .clk     (clk),
        .rst     (rst),
        .clear   (asm_clear),
        .capture (pend_q),
        .din     (bus.mem_din),
        .word    (asm_word),
        .cnt     (recv_cnt),
        .done    (asm_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (go) state_d = bus.cache_hit ? HIT : FETCH;
            end
            HIT: begin
                if (bus.rdy) state_d = IDLE;
            end
            FETCH: begin
                if (bus.rdy) begin
                    if (bus.flush)     state_d = IDLE;
                    else if (fill_done) state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d        = pc_q;
        issue_cnt_d = issue_cnt_q;
        pend_d      = issue;
        inst_o_d    = inst_o_q;
        inst_pc_d   = inst_pc_q;
        if ((state_q == IDLE) && go) begin
            if (bus.cache_hit) begin
                inst_o_d  = bus.cache_data_i;
                inst_pc_d = bus.if_pc;
            end else begin
                pc_d        = bus.if_pc;
                issue_cnt_d = '0;
            end
        end
        if (issue) issue_cnt_d = issue_cnt_q + cnt_t'(1);
        if ((state_q == RESP) && bus.rdy) begin
            inst_o_d  = asm_word;
            inst_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= '0;
            issue_cnt_q <= '0;
            pend_q      <= 1'b0;
            inst_o_q    <= '0;
            inst_pc_q   <= '0;
        end else begin
            pc_q        <= pc_d;
            issue_cnt_q <= issue_cnt_d;
            pend_q      <= pend_d;
            inst_o_q    <= inst_o_d;
            inst_pc_q   <= inst_pc_d;
        end
    end

    always_comb begin
        bus.cache_addr  = (state_q == IDLE) ? bus.if_pc : pc_q;
        bus.inst_valid  = 1'b0;
        bus.inst_o      = inst_o_q;
        bus.inst_pc     = inst_pc_q;
        bus.cache_work  = 1'b0;
        bus.cache_wdata = '0;
        bus.mem_req     = 1'b0;
        bus.mem_a       = '0;
        bus.mem_wr      = 1'b0;
        unique case (1'b1)
            (state_q == HIT): begin
                bus.inst_valid = bus.rdy & ~bus.flush;
            end
            (state_q == FETCH): begin
                bus.mem_req = more;
                if (issue) bus.mem_a = pc_q + ADDR_W'(issue_cnt_q);
            end
            (state_q == RESP): begin
                // A redirect here still fills the cache: the word is good.
                bus.cache_work  = bus.rdy;
                bus.cache_wdata = asm_word;
                bus.inst_valid  = bus.rdy & ~bus.flush;
                bus.inst_o      = asm_word;
                bus.inst_pc     = pc_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl with cache and RAM models.
module tb_icache_refill_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    icache_refill_ctrl_if #(.ADDR_W(32), .INST_W(32)) bus ();

    icache_refill_ctrl #(.ADDR_W(32), .INST_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] w;
    } exp_t;

    exp_t inst_q[$];
    exp_t wr_q[$];

    int total = 0;
    int bad   = 0;

    int          miss_id   = 0;
    logic [31:0] miss_base = 32'h0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        logic [31:0] k;
        logic [31:0] m;
        k = 32'h0010_0513;
        if (a[31:2] == 30'h400) return k[{a[1:0], 3'b000} +: 8];
        m = a * 32'd37;
        return m[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [31:0] ram_word(input logic [31:0] pc);
        return {ram_byte(pc + 3), ram_byte(pc + 2),
                ram_byte(pc + 1), ram_byte(pc)};
    endfunction

    // direct-mapped cache, 16 lines, full-address tag
    logic [15:0] cval = '0;
    logic [31:0] ctag[16];
    logic [31:0] cdat[16];

    always_comb begin
        bus.cache_hit    = cval[bus.cache_addr[5:2]]
                         && (ctag[bus.cache_addr[5:2]] == bus.cache_addr);
        bus.cache_data_i = cdat[bus.cache_addr[5:2]];
    end

    always @(posedge clk) begin
        if (bus.cache_work) begin
            cval[bus.cache_addr[5:2]] <= 1'b1;
            ctag[bus.cache_addr[5:2]] <= bus.cache_addr;
            cdat[bus.cache_addr[5:2]] <= bus.cache_wdata;
        end
    end

    function automatic bit env_hit(input logic [31:0] a);
        return cval[a[5:2]] && (ctag[a[5:2]] == a);
    endfunction

    always @(posedge clk) begin
        if (bus.mem_req && bus.mem_gnt) bus.mem_din <= ram_byte(bus.mem_a);
        else                            bus.mem_din <= 8'($urandom);
    end

    always @(negedge clk) begin : mon
        exp_t e;
        int   mk;
        int   seen_id;
        if (rst) begin
            chk("mem_wr", 64'(bus.mem_wr), 64'h0);
            if (bus.inst_valid) begin
                if (inst_q.size() == 0) begin
                    chk("inst_unexpected", 64'h1, 64'h0);
                end else begin
                    e = inst_q.pop_front();
                    chk("inst_pc", 64'(bus.inst_pc), 64'(e.pc));
                    chk("inst_o", 64'(bus.inst_o), 64'(e.w));
                end
            end
            if (bus.cache_work) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", 64'h1, 64'h0);
                end else begin
                    e = wr_q.pop_front();
                    chk("cache_addr", 64'(bus.cache_addr), 64'(e.pc));
                    chk("cache_wdata", 64'(bus.cache_wdata), 64'(e.w));
                end
            end
            if (seen_id != miss_id) begin
                seen_id = miss_id;
                mk      = 0;
            end
            if (bus.mem_req && bus.mem_gnt && bus.rdy && !bus.flush) begin
                chk("mem_a", 64'(bus.mem_a), 64'(miss_base + 32'(mk)));
                mk++;
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_inst_valid"}, 64'(bus.inst_valid), 64'h0);
        chk({tag, "_inst_o"}, 64'(bus.inst_o), 64'h0);
        chk({tag, "_inst_pc"}, 64'(bus.inst_pc), 64'h0);
        chk({tag, "_cache_work"}, 64'(bus.cache_work), 64'h0);
        chk({tag, "_cache_wdata"}, 64'(bus.cache_wdata), 64'h0);
        chk({tag, "_mem_req"}, 64'(bus.mem_req), 64'h0);
        chk({tag, "_mem_a"}, 64'(bus.mem_a), 64'h0);
        chk({tag, "_mem_wr"}, 64'(bus.mem_wr), 64'h0);
    endtask

    // mode 0: rdy/gnt high; 1: gnt low cycles 2-3; 2: rdy low cycles 3-5;
    // 3: random rdy/gnt. fl = cycle carrying flush (-1 none).
    task automatic run_fetch(input logic [31:0] pc, input int mode,
                             input int fl, input int lat);
        bit   hit;
        bit   seen;
        int   c;
        int   req_cyc;
        int   want;
        exp_t e;
        @(posedge clk);
        #1;
        hit  = env_hit(pc);
        e.pc = pc;
        e.w  = ram_word(pc);
        if (fl < 0) inst_q.push_back(e);
        if (!hit) begin
            if (fl < 0) wr_q.push_back(e);
            miss_base = pc;
            miss_id++;
        end
        want        = (mode == 0) ? (hit ? 1 : 6) : lat;
        bus.if_req  = 1'b1;
        bus.if_pc   = pc;
        bus.rdy     = 1'b1;
        bus.mem_gnt = 1'b1;
        bus.flush   = 1'b0;
        seen        = 1'b0;
        c           = 0;
        req_cyc     = 0;
        while (!seen && c < 80 && !(fl >= 0 && c >= fl + 6)) begin
            @(posedge clk);
            #1;
            c++;
            bus.if_req = 1'b0;
            bus.if_pc  = $urandom;
            bus.flush  = (c == fl);
            case (mode)
                1: begin
                    bus.rdy     = 1'b1;
                    bus.mem_gnt = !(c == 2 || c == 3);
                end
                2: begin
                    bus.rdy     = !(c >= 3 && c <= 5);
                    bus.mem_gnt = 1'b1;
                end
                3: begin
                    bus.rdy     = ($urandom_range(0, 3) != 0);
                    bus.mem_gnt = ($urandom_range(0, 2) != 0);
                end
                default: begin
                    bus.rdy     = 1'b1;
                    bus.mem_gnt = 1'b1;
                end
            endcase
            @(negedge clk);
            if (bus.mem_req) req_cyc++;
            if (bus.inst_valid) seen = 1'b1;
        end
        bus.flush = 1'b0;
        if (fl >= 0) begin
            chk("flush_quiet", 64'(seen), 64'h0);
        end else begin
            chk("fetch_done", 64'(seen), 64'h1);
            if (want > 0) chk("latency", 64'(c), 64'(want));
            if (hit && mode == 0) chk("hit_no_memreq", 64'(req_cyc), 64'h0);
        end
    endtask

    task automatic reset_mid(input logic [31:0] pc);
        @(posedge clk);
        #1;
        miss_base   = pc;
        miss_id++;
        bus.if_req  = 1'b1;
        bus.if_pc   = pc;
        bus.rdy     = 1'b1;
        bus.mem_gnt = 1'b1;
        bus.flush   = 1'b0;
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        bus.if_req  = 1'b0;
        bus.if_pc   = 32'h0;
        bus.rdy     = 1'b1;
        bus.flush   = 1'b0;
        bus.mem_gnt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        run_fetch(32'h0000_1000, 0, -1, 0);
        run_fetch(32'h0000_1000, 0, -1, 0);
        run_fetch(32'h0000_1008, 1, -1, 8);
        run_fetch(32'h0000_100C, 0, 3, 0);
        run_fetch(32'h0000_1000, 0, -1, 0);
        run_fetch(32'h0000_1000, 0, 1, 0);
        run_fetch(32'h0000_1010, 2, -1, 9);
        reset_mid(32'h0000_1014);
        run_fetch(32'h0000_1014, 0, -1, 0);
        run_fetch(32'hFFFF_FFFC, 0, -1, 0);
        run_fetch(32'h0000_100C, 0, -1, 0);

        for (int i = 0; i < 60; i++) begin
            run_fetch(32'h0000_2000 + 32'($urandom_range(0, 23)) * 32'd4,
                      ($urandom_range(0, 1) != 0) ? 3 : 0, -1, 0);
        end

        repeat (5) @(posedge clk);
        chk("inst_q_empty", 64'(inst_q.size()), 64'h0);
        chk("wr_q_empty", 64'(wr_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
